cr_fifo_rd_stage: RTL and testbench

CR_FIFO_RD_STAGE -- requirements
Module: cr_fifo_rd_stage

---
 rtl/cr_fifo_rd_stage.sv | 111 +++++++++++
 tb/tb_cr_fifo_rd_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cr_fifo_rd_stage.sv
`default_nettype none
// ============================================================================
// Module   : cr_fifo_rd_stage
// Brief    : Show-ahead FIFO read stage feeding a 2-entry registered
//            valid/ready output buffer, with flush and delivered-beat count.
// Revision : 1.0
// ============================================================================
module cr_fifo_rd_stage #(
  parameter int N_DATA_BITS = 64,
  parameter int N_CNT_BITS  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  input  logic [N_DATA_BITS-1:0] fifo_rdata,
  output logic                   fifo_ren,
  output logic                   out_valid,
  output logic [N_DATA_BITS-1:0] out_data,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   busy,
  output logic [N_CNT_BITS-1:0]  beat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_occ, w_occ_nxt, w_occ_after;
  logic [N_DATA_BITS-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic                   r_flush_done, w_done_nxt;
  logic [N_CNT_BITS-1:0]  r_beat_cnt;
  logic                   w_pop, w_ren;

  always_comb begin
    w_pop       = (r_occ != 2'd0) & out_ready;
    w_occ_after = r_occ - {1'b0, w_pop};
    w_state_nxt = r_state;
    w_occ_nxt   = w_occ_after;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_ren       = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_FLUSH: begin
        // Drain the FIFO; every popped word is dropped.
        w_ren     = ~fifo_empty;
        w_occ_nxt = 2'd0;
        if (fifo_empty) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_ren = ~fifo_empty & (w_occ_after < 2'd2);
        if (w_pop && (r_occ == 2'd2)) begin
          w_head_nxt = r_tail;
        end
        // New word lands in whichever slot is first free after this pop.
        if (w_ren) begin
          if (w_occ_after == 2'd0) begin
            w_head_nxt = fifo_rdata;
          end else begin
            w_tail_nxt = fifo_rdata;
          end
        end
        w_occ_nxt = w_occ_after + {1'b0, w_ren};
        if (flush) begin
          w_state_nxt = S_FLUSH;
          w_occ_nxt   = 2'd0;
        end else if ((r_state == S_IDLE) && !fifo_empty) begin
          w_state_nxt = S_RUN;
        end else if ((r_state == S_RUN) && (r_occ == 2'd0) && fifo_empty) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_occ        <= 2'd0;
      r_head       <= '0;
      r_tail       <= '0;
      r_flush_done <= 1'b0;
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_occ        <= w_occ_nxt;
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_flush_done <= w_done_nxt;
      r_beat_cnt   <= r_beat_cnt + N_CNT_BITS'(w_pop);
    end
  end

  // Gating with rst_n keeps the FIFO untouched for the whole reset window.
  assign fifo_ren   = w_ren & rst_n;
  assign out_valid  = (r_occ != 2'd0);
  assign out_data   = r_head;
  assign flush_done = r_flush_done;
  assign busy       = (r_state != S_IDLE) | (r_occ != 2'd0);
  assign beat_cnt   = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cr_fifo_rd_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_fifo_rd_stage
// Brief    : Directed + random bench for cr_fifo_rd_stage against a queue model.
// Revision : 1.0
// ============================================================================
module tb_cr_fifo_rd_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_ren;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          flush;
  logic          flush_done;
  logic          busy;
  logic [CW-1:0] beat_cnt;

  always #5 clk = ~clk;

  cr_fifo_rd_stage #(.N_DATA_BITS(DW), .N_CNT_BITS(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy),
    .beat_cnt   (beat_cnt)
  );

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] fq[$];     // environment FIFO contents
  logic [DW-1:0] bq[$];     // model of buffered, not-yet-delivered words
  logic [DW-1:0] got[$];    // words the DUT actually delivered
  int            mode;      // 0 idle, 1 running, 2 flushing
  logic          exp_done;
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    bq.delete();
    mode     = 0;
    exp_done = 1'b0;
    exp_cnt  = '0;
  endtask

  // One clock cycle: drive at +1 after posedge, check at negedge, advance model at posedge.
  task automatic step(input logic fl, input logic rdy, input logic avail);
    logic exp_ren, pop, dut_ren;
    int   occ0, occ_after;
    flush      = fl;
    out_ready  = rdy;
    fifo_empty = !(avail && (fq.size() > 0));
    fifo_rdata = (fq.size() > 0) ? fq[0] : '0;
    @(negedge clk);
    occ0      = bq.size();
    pop       = (occ0 != 0) && rdy;
    occ_after = occ0 - int'(pop);
    if (mode == 2) exp_ren = !fifo_empty;
    else           exp_ren = !fifo_empty && (occ_after < 2);
    chk("ren", fifo_ren, exp_ren);
    chk("valid", out_valid, occ0 != 0);
    if (occ0 != 0) chk("data", out_data, bq[0]);
    chk("busy", busy, (mode != 0) || (occ0 != 0));
    chk("flush_done", flush_done, exp_done);
    chk("beat_cnt", beat_cnt, exp_cnt);
    dut_ren = fifo_ren;
    if (out_valid && rdy) got.push_back(out_data);
    @(posedge clk);
    exp_done = 1'b0;
    if (pop) begin
      void'(bq.pop_front());
      exp_cnt = exp_cnt + 1'b1;
    end
    if (fl && mode != 2) begin
      bq.delete();
      mode = 2;
    end else if (mode == 2) begin
      if (fifo_empty) begin
        mode     = 0;
        exp_done = 1'b1;
      end
    end else begin
      if (exp_ren) bq.push_back(fifo_rdata);
      if (mode == 0 && !fifo_empty) mode = 1;
      else if (mode == 1 && occ0 == 0 && fifo_empty) mode = 0;
    end
    if (dut_ren && fq.size() > 0) void'(fq.pop_front());
    #1;
  endtask

  task automatic check_got(input string tag, input int first, input int n);
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk(tag, got[i], first + i);
  endtask

  initial begin
    int fq_before;
    flush = 0; out_ready = 0; fifo_rdata = '0;
    fq.delete();
    for (int i = 1; i <= 8; i++) fq.push_back(i);
    fifo_empty = 1'b0;
    fifo_rdata = fq[0];
    rst_n = 1'b0;
    model_clear();
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 0);
    chk("rst_ren", fifo_ren, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", flush_done, 1'b0);
    chk("rst_cnt", beat_cnt, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_no_pop", fq.size(), 8);
    rst_n = 1'b1;

    // Streaming run of 8 words.
    got.delete();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
    check_got("stream", 1, 8);
    chk("stream_cnt", beat_cnt, 8);

    // Backpressure: only two words may be pulled in.
    got.delete();
    for (int i = 1; i <= 4; i++) fq.push_back(i);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    chk("bp_pops", fq.size(), 2);
    chk("bp_hold", out_data, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);
    check_got("bp", 1, 4);

    // Flush with a full buffer and 3 words left in the FIFO.
    for (int i = 0; i < 5; i++) fq.push_back(32'hA0 + i);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    chk("fl_pre_fifo", fq.size(), 3);
    step(1'b1, 1'b0, 1'b1);
    chk("fl_valid", out_valid, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    chk("fl_drained", fq.size(), 0);
    chk("fl_busy", busy, 1'b0);

    // Random underrun: FIFO visible only every other cycle, random ready/flush.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) fq.push_back($urandom);
      step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), 1'(i % 2));
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b1);

    // Counter wrap: 17 beats from a fresh reset.
    rst_n = 1'b0; #1; model_clear();
    fq.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 1; i <= 17; i++) fq.push_back(i);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
    chk("wrap_cnt", beat_cnt, 1);

    // Reset mid-operation with a full buffer.
    for (int i = 11; i <= 16; i++) fq.push_back(i);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    fq_before  = fq.size();
    fifo_empty = 1'b0;
    fifo_rdata = fq[0];
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_cnt", beat_cnt, 0);
    chk("mrst_ren", fifo_ren, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("mrst_ren_hold", fifo_ren, 1'b0);
    @(posedge clk); #1;
    chk("mrst_no_pop", fq.size(), fq_before);
    rst_n = 1'b1;
    got.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);
    check_got("mrst_resume", 13, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
